// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand stage: the decoded operation code,
// the 4-bit ALU control values, the rotate flag position inside the shift
// operand and the selector values used by the sign-extend and count-leading
// operations.
package alu_pkg;

  // Codes 18..31 are not assigned and issue as a nop.
  typedef enum logic [4:0] {
    OP_AND   = 5'd0,
    OP_OR    = 5'd1,
    OP_ADD   = 5'd2,
    OP_NOR   = 5'd3,
    OP_XOR   = 5'd4,
    OP_SEXTB = 5'd5,
    OP_SEXTH = 5'd6,
    OP_SUB   = 5'd7,
    OP_SLT   = 5'd8,
    OP_MUL   = 5'd9,
    OP_SLL   = 5'd10,
    OP_SGT   = 5'd11,
    OP_CLZ   = 5'd12,
    OP_CLO   = 5'd13,
    OP_SRL   = 5'd14,
    OP_ROTR  = 5'd15,
    OP_SLTU  = 5'd16,
    OP_SRA   = 5'd17
  } op_t;

  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_NOR  = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SEXT = 4'd5;
  localparam logic [3:0] ALU_SUB  = 4'd6;
  localparam logic [3:0] ALU_SLT  = 4'd7;
  localparam logic [3:0] ALU_MUL  = 4'd9;
  localparam logic [3:0] ALU_SLL  = 4'd10;
  localparam logic [3:0] ALU_SGT  = 4'd11;
  localparam logic [3:0] ALU_CL   = 4'd12;
  localparam logic [3:0] ALU_SRL  = 4'd13;
  localparam logic [3:0] ALU_SLTU = 4'd14;
  localparam logic [3:0] ALU_SRA  = 4'd15;

  // Bit of the B operand that tells the shifter to rotate rather than shift.
  localparam int ROTR_BIT = 5;

  // B-operand selectors for the unary ops.
  localparam logic SEXT_B_SEL = 1'b0;
  localparam logic SEXT_H_SEL = 1'b1;
  localparam logic CL_Z_SEL   = 1'b0;
  localparam logic CL_O_SEL   = 1'b1;

  function automatic logic is_shift(input logic [4:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_ROTR) || (op == OP_SRA);
  endfunction

  function automatic logic is_sext(input logic [4:0] op);
    return (op == OP_SEXTB) || (op == OP_SEXTH);
  endfunction

endpackage

// File: rtl/alu_fwd_mux.sv
// Source-operand forwarding for one register index.
// Ports:
//   idx       register index being read (index 0 always reads zero)
//   reg_data  value read from the register file
//   exm_*     EX/MEM forward source (highest priority)
//   wb_*      writeback forward source
//   data      resolved operand value
module alu_fwd_mux #(
  parameter int W = 32
) (
  input  logic [4:0]   idx,
  input  logic [W-1:0] reg_data,
  input  logic         exm_wen,
  input  logic [4:0]   exm_rd,
  input  logic [W-1:0] exm_data,
  input  logic         wb_wen,
  input  logic [4:0]   wb_rd,
  input  logic [W-1:0] wb_data,
  output logic [W-1:0] data
);

  // The youngest in-flight write (EX/MEM) wins over the older writeback.
  always_comb begin
    if (idx == 5'd0) begin
      data = '0;
    end else if (exm_wen && (exm_rd == idx)) begin
      data = exm_data;
    end else if (wb_wen && (wb_rd == idx)) begin
      data = wb_data;
    end else begin
      data = reg_data;
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// ALU operand stage: resolves source operands with forwarding, detects
// load-use hazards, maps the decoded op to ALU control and operands, and holds
// the result in a single output register with a valid/ready handshake.
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   flush                       drop the held operation
//   in_valid/in_ready           decoded-op handshake
//   in_op, in_rs_idx, in_rt_idx, in_rd, in_rs_data, in_rt_data, in_imm,
//   in_use_imm                  decoded operation fields
//   exm_wen, exm_is_load, exm_rd, exm_data   EX/MEM forward source
//   wb_wen, wb_rd, wb_data      writeback forward source
//   out_valid/out_ready         ALU-side handshake
//   alu_ctrl, alu_a, alu_b, out_rd           registered ALU inputs
//   stall_cnt                   saturating count of load-use stall cycles
module alu_operand_stage
  import alu_pkg::*;
#(
  parameter int W     = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_op,
  input  logic [4:0]       in_rs_idx,
  input  logic [4:0]       in_rt_idx,
  input  logic [4:0]       in_rd,
  input  logic [W-1:0]     in_rs_data,
  input  logic [W-1:0]     in_rt_data,
  input  logic [W-1:0]     in_imm,
  input  logic             in_use_imm,
  input  logic             exm_wen,
  input  logic             exm_is_load,
  input  logic [4:0]       exm_rd,
  input  logic [W-1:0]     exm_data,
  input  logic             wb_wen,
  input  logic [4:0]       wb_rd,
  input  logic [W-1:0]     wb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       alu_ctrl,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  output logic [4:0]       out_rd,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [W-1:0] rs_val;
  logic [W-1:0] rt_val;

  alu_fwd_mux #(.W(W)) u_fwd_rs (
    .idx      (in_rs_idx),
    .reg_data (in_rs_data),
    .exm_wen  (exm_wen),
    .exm_rd   (exm_rd),
    .exm_data (exm_data),
    .wb_wen   (wb_wen),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .data     (rs_val)
  );

  alu_fwd_mux #(.W(W)) u_fwd_rt (
    .idx      (in_rt_idx),
    .reg_data (in_rt_data),
    .exm_wen  (exm_wen),
    .exm_rd   (exm_rd),
    .exm_data (exm_data),
    .wb_wen   (wb_wen),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .data     (rt_val)
  );

  // Hazard detection: a load still in EX/MEM cannot be forwarded yet, so an
  // op that actually reads its destination must wait a cycle.
  logic uses_rs;
  logic uses_rt;
  logic hazard;
  logic accept;

  always_comb begin
    uses_rs = !((is_shift(in_op) && in_use_imm) || is_sext(in_op));
    uses_rt = !in_use_imm;
    hazard  = in_valid && exm_wen && exm_is_load && (exm_rd != 5'd0) &&
              ((uses_rs && (exm_rd == in_rs_idx)) ||
               (uses_rt && (exm_rd == in_rt_idx)));
  end

  // Reset is folded in so nothing is taken while the stage is being cleared.
  assign in_ready = rst_n && (!out_valid || out_ready) && !hazard && !flush;
  assign accept   = in_valid && in_ready;

  // Decode into the next contents of the output register.
  logic [3:0]   nxt_ctrl;
  logic [W-1:0] nxt_a;
  logic [W-1:0] nxt_b;
  logic [4:0]   nxt_rd;
  logic [4:0]   shamt;

  // NOTE: every signal gets a default at the top of the block so no path
  // through the case leaves one unassigned and infers a latch.
  always_comb begin
    nxt_ctrl = ALU_ADD;
    nxt_a    = rs_val;
    nxt_b    = in_use_imm ? in_imm : rt_val;
    nxt_rd   = in_rd;
    shamt    = in_use_imm ? in_imm[4:0] : rs_val[4:0];

    case (in_op)
      OP_AND:  nxt_ctrl = ALU_AND;
      OP_OR:   nxt_ctrl = ALU_OR;
      OP_ADD:  nxt_ctrl = ALU_ADD;
      OP_NOR:  nxt_ctrl = ALU_NOR;
      OP_XOR:  nxt_ctrl = ALU_XOR;
      OP_SUB:  nxt_ctrl = ALU_SUB;
      OP_SLT:  nxt_ctrl = ALU_SLT;
      OP_MUL:  nxt_ctrl = ALU_MUL;
      OP_SGT:  nxt_ctrl = ALU_SGT;
      OP_SLTU: nxt_ctrl = ALU_SLTU;
      OP_SEXTB: begin
        nxt_ctrl = ALU_SEXT;
        nxt_b    = W'(SEXT_B_SEL);
      end
      OP_SEXTH: begin
        nxt_ctrl = ALU_SEXT;
        nxt_b    = W'(SEXT_H_SEL);
      end
      OP_CLZ: begin
        nxt_ctrl = ALU_CL;
        nxt_b    = W'(CL_Z_SEL);
      end
      OP_CLO: begin
        nxt_ctrl = ALU_CL;
        nxt_b    = W'(CL_O_SEL);
      end
      // Shifts move the shifted value to A and pack amount + rotate flag in B.
      OP_SLL, OP_SRL, OP_ROTR, OP_SRA: begin
        case (in_op)
          OP_SLL:  nxt_ctrl = ALU_SLL;
          OP_SRA:  nxt_ctrl = ALU_SRA;
          default: nxt_ctrl = ALU_SRL;
        endcase
        nxt_a           = rt_val;
        nxt_b           = '0;
        nxt_b[4:0]      = shamt;
        nxt_b[ROTR_BIT] = (in_op == OP_ROTR);
      end
      default: begin
        nxt_ctrl = ALU_ADD;
        nxt_a    = '0;
        nxt_b    = '0;
        nxt_rd   = 5'd0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      alu_ctrl  <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      out_rd    <= '0;
      stall_cnt <= '0;
    end else begin
      if (hazard && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end

      // Flush only kills the valid bit; the data registers keep their values.
      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid <= 1'b1;
        alu_ctrl  <= nxt_ctrl;
        alu_a     <= nxt_a;
        alu_b     <= nxt_b;
        out_rd    <= nxt_rd;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Randomised scoreboard bench for alu_operand_stage with directed scenarios.
module tb_alu_operand_stage;
  import alu_pkg::*;

  localparam int W     = 32;
  localparam int CNT_W = 4;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       in_op;
  logic [4:0]       in_rs_idx, in_rt_idx, in_rd;
  logic [W-1:0]     in_rs_data, in_rt_data, in_imm;
  logic             in_use_imm;
  logic             exm_wen, exm_is_load;
  logic [4:0]       exm_rd;
  logic [W-1:0]     exm_data;
  logic             wb_wen;
  logic [4:0]       wb_rd;
  logic [W-1:0]     wb_data;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       alu_ctrl;
  logic [W-1:0]     alu_a, alu_b;
  logic [4:0]       out_rd;
  logic [CNT_W-1:0] stall_cnt;

  alu_operand_stage #(.W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs_idx(in_rs_idx), .in_rt_idx(in_rt_idx), .in_rd(in_rd),
    .in_rs_data(in_rs_data), .in_rt_data(in_rt_data), .in_imm(in_imm),
    .in_use_imm(in_use_imm),
    .exm_wen(exm_wen), .exm_is_load(exm_is_load), .exm_rd(exm_rd), .exm_data(exm_data),
    .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b), .out_rd(out_rd),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   ctrl;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [4:0]   rd;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  bit   m_valid = 0;
  int   m_stall = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] resolve(input logic [4:0] idx, input logic [W-1:0] rf);
    if (idx == 0) return '0;
    if (exm_wen && exm_rd == idx) return exm_data;
    if (wb_wen && wb_rd == idx) return wb_data;
    return rf;
  endfunction

  // ALU control for each op; -1 marks an undefined op.
  function automatic int ctrl_of(input logic [4:0] op);
    case (op)
      5'd0:  return 0;   // AND
      5'd1:  return 1;   // OR
      5'd2:  return 2;   // ADD
      5'd3:  return 3;   // NOR
      5'd4:  return 4;   // XOR
      5'd5:  return 5;   // SEXTB
      5'd6:  return 5;   // SEXTH
      5'd7:  return 6;   // SUB
      5'd8:  return 7;   // SLT
      5'd9:  return 9;   // MUL
      5'd10: return 10;  // SLL
      5'd11: return 11;  // SGT
      5'd12: return 12;  // CLZ
      5'd13: return 12;  // CLO
      5'd14: return 13;  // SRL
      5'd15: return 13;  // ROTR
      5'd16: return 14;  // SLTU
      5'd17: return 15;  // SRA
      default: return -1;
    endcase
  endfunction

  function automatic bit shift_op(input logic [4:0] op);
    return op == 5'd10 || op == 5'd14 || op == 5'd15 || op == 5'd17;
  endfunction

  function automatic bit model_hazard();
    bit use_rs, use_rt;
    use_rs = !(shift_op(in_op) && in_use_imm) && !(in_op == 5'd5 || in_op == 5'd6);
    use_rt = !in_use_imm;
    return in_valid && exm_wen && exm_is_load && exm_rd != 0 &&
           ((use_rs && exm_rd == in_rs_idx) || (use_rt && exm_rd == in_rt_idx));
  endfunction

  function automatic exp_t model_op();
    exp_t e;
    logic [W-1:0] rs_v, rt_v;
    int c;
    rs_v = resolve(in_rs_idx, in_rs_data);
    rt_v = resolve(in_rt_idx, in_rt_data);
    c = ctrl_of(in_op);
    if (c < 0) begin
      e.ctrl = 4'd2; e.a = 0; e.b = 0; e.rd = 0;
      return e;
    end
    e.ctrl = c[3:0];
    e.rd   = in_rd;
    e.a    = rs_v;
    e.b    = in_use_imm ? in_imm : rt_v;
    if (shift_op(in_op)) begin
      e.a = rt_v;
      e.b = {26'b0, (in_op == 5'd15), (in_use_imm ? in_imm[4:0] : rs_v[4:0])};
    end else if (in_op == 5'd5 || in_op == 5'd12) begin
      e.b = 0;
    end else if (in_op == 5'd6 || in_op == 5'd13) begin
      e.b = 1;
    end
    return e;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("out_valid", out_valid, sbq.size() != 0);
      if (out_valid === 1'b1 && sbq.size() != 0) begin
        check("alu_ctrl", alu_ctrl, sbq[0].ctrl);
        check("alu_a", alu_a, sbq[0].a);
        check("alu_b", alu_b, sbq[0].b);
        check("out_rd", out_rd, sbq[0].rd);
        if (out_ready) void'(sbq.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  // One clock: check in_ready, update the model, push accepted ops, then
  // step past the edge and check the stall counter.
  task automatic step();
    bit hz, rdy;
    @(negedge clk); #1;
    hz  = rst_n && model_hazard();
    rdy = rst_n && (!m_valid || out_ready) && !hz && !flush;
    check("in_ready", in_ready, rdy);
    if (!rst_n) begin
      sbq.delete();
      m_valid = 0;
      m_stall = 0;
    end else begin
      if (hz && m_stall < SAT) m_stall++;
      if (flush) begin
        if (m_valid && !out_ready && sbq.size() != 0) void'(sbq.pop_back());
        m_valid = 0;
      end else if (in_valid && rdy) begin
        sbq.push_back(model_op());
        m_valid = 1;
      end else if (out_ready) begin
        m_valid = 0;
      end
    end
    @(posedge clk); #1;
    check("stall_cnt", stall_cnt, m_stall[CNT_W-1:0]);
  endtask

  task automatic idle();
    flush = 0; in_valid = 0; in_op = 5'd2; in_rs_idx = 0; in_rt_idx = 0; in_rd = 0;
    in_rs_data = 0; in_rt_data = 0; in_imm = 0; in_use_imm = 0;
    exm_wen = 0; exm_is_load = 0; exm_rd = 0; exm_data = 0;
    wb_wen = 0; wb_rd = 0; wb_data = 0; out_ready = 1;
  endtask

  task automatic op(input logic [4:0] o, input logic [4:0] rs, input logic [W-1:0] rsd,
                    input logic [4:0] rt, input logic [W-1:0] rtd,
                    input logic [W-1:0] imm, input logic ui, input logic [4:0] rd);
    in_valid = 1; in_op = o; in_rs_idx = rs; in_rs_data = rsd;
    in_rt_idx = rt; in_rt_data = rtd; in_imm = imm; in_use_imm = ui; in_rd = rd;
  endtask

  task automatic drain();
    idle();
    step();
    step();
  endtask

  initial begin
    rst_n = 0;
    idle();
    step();
    step();
    check("rst_out_valid", out_valid, 0);
    check("rst_alu_ctrl", alu_ctrl, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_out_rd", out_rd, 0);
    rst_n = 1;

    // Plain ADD.
    op(OP_ADD, 5'd3, 32'd5, 5'd4, 32'd7, 0, 0, 5'd9);
    step();
    check("add_ctrl", alu_ctrl, 2);
    check("add_a", alu_a, 5);
    check("add_b", alu_b, 7);
    check("add_valid", out_valid, 1);
    drain();

    // Forwarding priority and index zero.
    op(OP_SUB, 5'd3, 32'd1, 5'd6, 32'd2, 0, 0, 5'd1);
    exm_wen = 1; exm_rd = 3; exm_data = 32'h10;
    wb_wen = 1; wb_rd = 3; wb_data = 32'h20;
    step();
    check("fwd_exm_prio", alu_a, 32'h10);
    op(OP_SUB, 5'd0, 32'h99, 5'd6, 32'd2, 0, 0, 5'd1);
    exm_rd = 0; exm_data = 32'h55;
    step();
    check("fwd_zero_idx", alu_a, 0);
    drain();

    // Load-use stall, then issue with the forwarded value.
    op(OP_ADD, 5'd1, 32'd3, 5'd4, 32'd8, 0, 0, 5'd2);
    exm_wen = 1; exm_is_load = 1; exm_rd = 4; exm_data = 32'h77;
    step();
    check("stall_one", stall_cnt, 1);
    check("stall_no_issue", out_valid, 0);
    exm_is_load = 0;
    step();
    check("after_stall_b", alu_b, 32'h77);
    check("after_stall_a", alu_a, 3);
    drain();

    // Rotate / shift by immediate.
    op(OP_ROTR, 5'd2, 32'h1234, 5'd5, 32'hDEADBEEF, 32'd8, 1, 5'd7);
    step();
    check("rotr_ctrl", alu_ctrl, 13);
    check("rotr_a", alu_a, 32'hDEADBEEF);
    check("rotr_b", alu_b, 32'h28);
    op(OP_SRL, 5'd2, 32'h1234, 5'd5, 32'hDEADBEEF, 32'd8, 1, 5'd7);
    step();
    check("srl_b", alu_b, 32'h08);
    drain();

    // Back-pressure: hold, then replace on the draining edge.
    out_ready = 0;
    op(OP_OR, 5'd1, 32'hA, 5'd2, 32'hB, 0, 0, 5'd3);
    step();
    op(OP_XOR, 5'd1, 32'hC0DE, 5'd2, 32'hB, 0, 0, 5'd4);
    for (int i = 0; i < 3; i++) step();
    check("bp_frozen_a", alu_a, 32'hA);
    out_ready = 1;
    step();
    check("bp_replace_a", alu_a, 32'hC0DE);
    check("bp_replace_valid", out_valid, 1);
    drain();

    // Flush beats a same-cycle accept.
    op(OP_AND, 5'd1, 32'h1, 5'd2, 32'h2, 0, 0, 5'd5);
    flush = 1;
    step();
    check("flush_valid", out_valid, 0);
    flush = 0;
    drain();

    // Stall saturation, then reset in the middle of a stall.
    op(OP_ADD, 5'd4, 32'd1, 5'd2, 32'd2, 0, 0, 5'd5);
    exm_wen = 1; exm_is_load = 1; exm_rd = 4;
    for (int i = 0; i < SAT + 4; i++) step();
    check("stall_sat", stall_cnt, SAT);
    rst_n = 0;
    step();
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_a", alu_a, 0);
    rst_n = 1;
    drain();

    // Randomised traffic.
    for (int n = 0; n < 2000; n++) begin
      rst_n       = ($urandom_range(0, 199) != 0);
      flush       = ($urandom_range(0, 15) == 0);
      in_valid    = ($urandom_range(0, 4) != 0);
      in_op       = ($urandom_range(0, 4) != 0) ? 5'($urandom_range(0, 17)) : 5'($urandom_range(18, 31));
      in_rs_idx   = 5'($urandom_range(0, 7));
      in_rt_idx   = 5'($urandom_range(0, 7));
      in_rd       = 5'($urandom_range(0, 31));
      in_rs_data  = $urandom();
      in_rt_data  = $urandom();
      in_imm      = ($urandom_range(0, 1) != 0) ? $urandom() : 32'($urandom_range(0, 63));
      in_use_imm  = ($urandom_range(0, 2) == 0);
      exm_wen     = ($urandom_range(0, 1) != 0);
      exm_is_load = ($urandom_range(0, 3) == 0);
      exm_rd      = 5'($urandom_range(0, 7));
      exm_data    = $urandom();
      wb_wen      = ($urandom_range(0, 1) != 0);
      wb_rd       = 5'($urandom_range(0, 7));
      wb_data     = $urandom();
      out_ready   = ($urandom_range(0, 3) != 0);
      step();
    end
    rst_n = 1;
    drain();
    check("final_queue_empty", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
